// File: rtl/lane_queue_tracker.sv
// Per-lane car counters for the auto-change-lanes intersection.
// Arrivals come from rising edges on the lane sensors; the granted lane drains at a fixed rate while green.

module lane_queue_tracker_lane #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arr,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);
  localparam logic [CNT_W-1:0] CAP = '1;

  // Arrival and departure on the same edge cancel, even when the lane is full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (arr && !dec) begin
      if (count == CAP) overflow <= 1'b1;
      else              count    <= count + CNT_W'(1);
    end else if (!arr && dec) begin
      count <= count - CNT_W'(1);
    end
  end
endmodule

module lane_queue_tracker #(
  parameter int CNT_W         = 3,
  parameter int DEPART_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         arrive,
  input  logic [1:0]         cur_state,
  input  logic               go,
  output logic               lane0_has1,
  output logic               lane1_has1,
  output logic               lane2_has1,
  output logic               lane3_has1,
  output logic [4*CNT_W-1:0] lane_counts,
  output logic [3:0]         overflow,
  output logic               depart
);
  localparam int NUM_LANES = 4;
  localparam logic [7:0] TMR_LAST = 8'(DEPART_CYCLES - 1);

  logic [NUM_LANES-1:0][CNT_W-1:0] counts;
  logic [NUM_LANES-1:0]            arr, dec;
  logic [3:0]                      arrive_q;
  logic [1:0]                      cur_state_q;
  logic [7:0]                      timer;
  logic                            dep_ok, dep_evt;

  assign arr = arrive & ~arrive_q;

  // A lane switch makes dep_ok false for one edge, which also clears the timer.
  assign dep_ok  = go && (counts[cur_state] != '0) && (cur_state == cur_state_q);
  assign dep_evt = dep_ok && (timer == TMR_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      arrive_q    <= 4'b1111;
      cur_state_q <= 2'b00;
      timer       <= 8'd0;
      depart      <= 1'b0;
    end else begin
      arrive_q    <= arrive;
      cur_state_q <= cur_state;
      depart      <= dep_evt;
      if (!dep_ok || dep_evt) timer <= 8'd0;
      else                    timer <= timer + 8'd1;
    end
  end

  genvar n;
  generate
    for (n = 0; n < NUM_LANES; n++) begin : g_lane
      assign dec[n] = dep_evt && (cur_state == 2'(n));
      lane_queue_tracker_lane #(.CNT_W(CNT_W)) u_lane (
        .clk      (clk),
        .rst_n    (rst_n),
        .arr      (arr[n]),
        .dec      (dec[n]),
        .count    (counts[n]),
        .overflow (overflow[n])
      );
    end
  endgenerate

  assign lane_counts = counts;
  assign lane0_has1  = counts[0] != '0;
  assign lane1_has1  = counts[1] != '0;
  assign lane2_has1  = counts[2] != '0;
  assign lane3_has1  = counts[3] != '0;
endmodule

// File: doc/lane_queue_tracker.md
# lane_queue_tracker

Tracks how many cars wait in each of the four lanes of the auto-change-lanes intersection and produces the per-lane occupancy flags (`lane0_has1`..`lane3_has1`) consumed by the lane-selection input logic. It counts arrivals from four lane sensor/switch inputs and retires cars from the currently granted lane (`cur_state`) at a fixed departure rate while green. It sits between the board switches and the lane-selection FSM, closing the loop on `cur_state`.

## Interface
- `CNT_W`, 3: width of each lane counter; lane capacity is 2^CNT_W-1 cars.
- `DEPART_CYCLES`, 4: green cycles per car departure; legal range is 1 to 255.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, synchronous and active-low; one clock.
- `arrive`  in  4  raw lane sensor levels; bit N is lane N. A rising edge is one car arrival.
- `cur_state`  in  2  lane currently granted green (00 to 11).
- `go`  in  1  green active; 0 freezes departures, for example during yellow or all-red.
- `lane0_has1`..`lane3_has1`  out  1 each  lane N count is nonzero.
- `lane_counts`  out  4*CNT_W  lane N count at bits [N*CNT_W +: CNT_W].
- `overflow`  out  4  sticky per-lane flag: an arrival was dropped at capacity.
- `depart`  out  1  one-cycle pulse: a car left the granted lane.

## Operation
- Reset (`rst_n`=0 at an edge):
  - counts 0, `overflow` 0000, departure timer 0, `depart` 0.
  - `cur_state_q` is 00.
  - `arrive_q` is 1111, so a switch held high through reset is not counted.
- Arrival detect: `arr[N] = arrive[N] & ~arrive_q[N]`. `arrive_q` is updated every edge.
- Departure condition `dep_ok`: `go`=1, count[`cur_state`]≠0 and `cur_state`==`cur_state_q`.
- Departure timer (8 bits):
  - If `dep_ok`=0: timer cleared to 0.
  - If `dep_ok`=1 and timer==DEPART_CYCLES-1: departure event; timer goes to 0.
  - Otherwise: timer increments.
- Lane switch: `cur_state`≠`cur_state_q` clears the timer. No departure can occur on that edge. `cur_state_q` is updated every edge.
- Per-lane counter update each edge, with `d[N]` = departure event and `cur_state`==N:
  - `arr`=1, `d`=0: +1. At capacity, the count holds and `overflow[N]` is set.
  - `arr`=0, `d`=1: −1. Never underflows, since a departure requires a nonzero count.
  - Both 1: count unchanged, no overflow even at capacity.
  - Both 0: hold.
- `overflow` bits clear only on reset.
- `depart` is registered and equals the departure event of the previous edge.
- `laneN_has1` and `lane_counts` are driven directly from the count registers; there is no extra decode register.

## Timing
- Arrival latency: `arrive[N]` low at edge k-1 and high at edge k → count increments at edge k. `laneN_has1` is valid after edge k.
- A held-high `arrive` counts once. Re-arming requires at least one low sample.
- Departure rate: with `dep_ok` continuously true from edge k onward, departures occur at edges k+DEPART_CYCLES-1, k+2·DEPART_CYCLES-1, and so on. With DEPART_CYCLES=1, a car departs every cycle.
- The first green cycle after a lane switch only clears the timer. The first departure follows DEPART_CYCLES edges later.
- `depart` is high for exactly the one cycle after each departure edge. The decremented count is visible in the same cycle.
- Dropping `go` mid-interval discards the partial timer; progress is not retained.
- Reset mid-interval: all state returns to reset values at that edge, and `depart` is 0 the next cycle.
- Arrivals on all four lanes in the same cycle are all counted.
- Arrivals on non-granted lanes never interact with the timer.

## Test plan
- Reset then basic arrival:
  - Stimulus: `arrive` held 0001 through reset, then 0, then pulsed 0001 twice.
  - Required: lane 0 count 2, `lane0_has1`=1, other flags 0; the reset-held level is not counted.
- Departure rate:
  - Stimulus: lane 2 count 3, `cur_state`=10, `go`=1, DEPART_CYCLES=4.
  - Required: `depart` pulses 4 cycles apart, three times; count reaches 0; `lane2_has1` falls with the third decrement; no further pulses.
- Simultaneous arrival and departure:
  - Stimulus: a lane 1 arrival edge coincides with a lane 1 departure edge.
  - Required: count unchanged, `depart`=1 next cycle, `overflow`=0000.
- Overflow saturation:
  - Stimulus: 9 arrival pulses on lane 3 with CNT_W=3 and `go`=0.
  - Required: count 7, `overflow`=1000, which stays set afterwards when cars depart.
- Lane switch and go gating:
  - Stimulus: `cur_state` changes 00→01 at timer=2; separately, `go` drops for 1 cycle at timer=3.
  - Required: no departure at the switch; the next departure comes 4 cycles after the switch, or 4 cycles after `go` returns.
- Reset mid-operation:
  - Stimulus: assert `rst_n`=0 for one edge while counts are nonzero and the timer is running.
  - Required: all counts 0, all `laneN_has1` 0, `overflow` 0000, `depart` 0 the next cycle.
